// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline control logic:
// EX operand mux select encodings and the register-match function used by forwarding.
package mips_pkg;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // True when a pipeline stage writes a real register that the consumer reads.
   function automatic logic fwd_hit(input logic             wr,
                                    input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] src);
      return wr && (dst != REG_ZERO) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Mult/div occupancy counter: loads MD_LATENCY when a mult/div issues,
// then counts down to zero; md_busy is high while the count is nonzero.
module hazard_md_counter #(
   parameter int MD_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic md_busy
);

   localparam int CW = $clog2(MD_LATENCY + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CW'(MD_LATENCY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // NOTE: state flops use non-blocking assignment so all registers sample together.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Optional macro BRANCH_FWD_EN: forward MEM ALU results into the decode branch compare.
module hazard_unit #(
   parameter int REG_AW     = mips_pkg::REG_AW,
   parameter int MD_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic [REG_AW-1:0] dst_d,
   input  logic              regwrite_d,
   input  logic              memtoreg_d,
   input  logic              branch_d,
   input  logic              md_start_d,
   input  logic              md_read_d,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              fwd_a_d,
   output logic              fwd_b_d,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_e,
   output logic              md_busy
);

   import mips_pkg::*;

   typedef struct packed {
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dst;
      logic              regwrite;
      logic              memtoreg;
   } e_shadow_t;

   // MEM keeps memtoreg as well: a load still in MEM cannot feed a decode branch.
   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic              regwrite;
      logic              memtoreg;
   } m_shadow_t;

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic              regwrite;
   } w_shadow_t;

   e_shadow_t e_q, e_d;
   m_shadow_t m_q, m_d;
   w_shadow_t w_q, w_d;

   logic stall;
   logic lw_stall, br_stall, md_stall;
   logic ex_br_hit, mem_ld_hit, mem_alu_a, mem_alu_b;
   logic md_load;

   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.rs       = rs_d;
         e_d.rt       = rt_d;
         e_d.dst      = dst_d;
         e_d.regwrite = regwrite_d;
         e_d.memtoreg = memtoreg_d;
      end
      m_d          = '0;
      m_d.dst      = e_q.dst;
      m_d.regwrite = e_q.regwrite;
      m_d.memtoreg = e_q.memtoreg;
      w_d          = '0;
      w_d.dst      = m_q.dst;
      w_d.regwrite = m_q.regwrite;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   always_comb begin
      fwd_a_e = FWD_RF;
      if (fwd_hit(m_q.regwrite, m_q.dst, e_q.rs)) begin
         fwd_a_e = FWD_MEM;
      end else if (fwd_hit(w_q.regwrite, w_q.dst, e_q.rs)) begin
         fwd_a_e = FWD_WB;
      end
      fwd_b_e = FWD_RF;
      if (fwd_hit(m_q.regwrite, m_q.dst, e_q.rt)) begin
         fwd_b_e = FWD_MEM;
      end else if (fwd_hit(w_q.regwrite, w_q.dst, e_q.rt)) begin
         fwd_b_e = FWD_WB;
      end
   end

   assign lw_stall   = fwd_hit(e_q.memtoreg, e_q.dst, rs_d) || fwd_hit(e_q.memtoreg, e_q.dst, rt_d);
   assign ex_br_hit  = fwd_hit(e_q.regwrite, e_q.dst, rs_d) || fwd_hit(e_q.regwrite, e_q.dst, rt_d);
   assign mem_ld_hit = fwd_hit(m_q.memtoreg, m_q.dst, rs_d) || fwd_hit(m_q.memtoreg, m_q.dst, rt_d);
   assign mem_alu_a  = fwd_hit(m_q.regwrite, m_q.dst, rs_d);
   assign mem_alu_b  = fwd_hit(m_q.regwrite, m_q.dst, rt_d);

`ifdef BRANCH_FWD_EN
   assign br_stall = branch_d && (ex_br_hit || mem_ld_hit);
   assign fwd_a_d  = mem_alu_a;
   assign fwd_b_d  = mem_alu_b;
`else
   // Without the decode bypass the branch waits until its producer reaches WB.
   assign br_stall = branch_d && (ex_br_hit || mem_ld_hit || mem_alu_a || mem_alu_b);
   assign fwd_a_d  = 1'b0;
   assign fwd_b_d  = 1'b0;
`endif

   assign md_stall = (md_read_d || md_start_d) && md_busy;
   assign stall    = lw_stall || br_stall || md_stall;
   assign stall_f  = stall;
   assign stall_d  = stall;
   assign flush_e  = stall;
   assign md_load  = md_start_d && !stall;

   hazard_md_counter #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_counter (
      .clk     (clk),
      .reset   (reset),
      .load    (md_load),
      .md_busy (md_busy)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each cycle's directed vector pushes its expected
// outputs into a queue; a negedge monitor pops and compares them against the DUT.
module tb_hazard_unit;

   import mips_pkg::*;

`ifdef BRANCH_FWD_EN
   localparam bit BFWD = 1'b1;
`else
   localparam bit BFWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs_d = '0, rt_d = '0, dst_d = '0;
   logic       regwrite_d = 1'b0, memtoreg_d = 1'b0, branch_d = 1'b0;
   logic       md_start_d = 1'b0, md_read_d = 1'b0;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic       fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, md_busy;

   hazard_unit dut (
      .clk        (clk),
      .reset      (reset),
      .rs_d       (rs_d),
      .rt_d       (rt_d),
      .dst_d      (dst_d),
      .regwrite_d (regwrite_d),
      .memtoreg_d (memtoreg_d),
      .branch_d   (branch_d),
      .md_start_d (md_start_d),
      .md_read_d  (md_read_d),
      .fwd_a_e    (fwd_a_e),
      .fwd_b_e    (fwd_b_e),
      .fwd_a_d    (fwd_a_d),
      .fwd_b_d    (fwd_b_d),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .flush_e    (flush_e),
      .md_busy    (md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         chk;
      logic [1:0] fa;
      logic [1:0] fb;
      bit         da;
      bit         db;
      bit         st;
      bit         bz;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, req, $time);
      end
   endtask

   // Drive one decode-stage vector after the edge and record what the DUT must show.
   // da/db are the decode-bypass values with the bypass built in; otherwise they must be 0.
   task automatic iss(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input bit rw, input bit mtr, input bit br,
                      input bit mds, input bit mdr, input bit chk,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input bit da, input bit db, input bit st, input bit bz);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = rst;
      rs_d       = rs;
      rt_d       = rt;
      dst_d      = dst;
      regwrite_d = rw;
      memtoreg_d = mtr;
      branch_d   = br;
      md_start_d = mds;
      md_read_d  = mdr;
      e.chk = chk;
      e.fa  = fa;
      e.fb  = fb;
      e.da  = da && BFWD;
      e.db  = db && BFWD;
      e.st  = st;
      e.bz  = bz;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.chk) begin
            check("fwd_a_e", fwd_a_e, e.fa);
            check("fwd_b_e", fwd_b_e, e.fb);
            check("fwd_a_d", {1'b0, fwd_a_d}, {1'b0, e.da});
            check("fwd_b_d", {1'b0, fwd_b_d}, {1'b0, e.db});
            check("stall_f", {1'b0, stall_f}, {1'b0, e.st});
            check("stall_d", {1'b0, stall_d}, {1'b0, e.st});
            check("flush_e", {1'b0, flush_e}, {1'b0, e.st});
            check("md_busy", {1'b0, md_busy}, {1'b0, e.bz});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //  rst rs rt dst rw mt br ms mr chk fa       fb       da db st bz
      iss(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0); // reset state
      // add $3 ; add $4,$3,$5
      iss(0, 1, 2, 3, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 3, 5, 4, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_MEM, FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // add $3 ; nop ; sub $6,$1,$3
      iss(0, 1, 2, 3, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 1, 3, 6, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 1, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_WB,  0, 0, 0, 0);
      // add $3 ; add $3 ; sub $6,$1,$3 -> MEM beats WB
      iss(0, 1, 2, 3, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 1, 2, 3, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 1, 3, 6, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 1, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_MEM, 0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // lw $2 ; add $4,$2,$2 -> one load-use stall
      iss(0, 1, 2, 2, 1, 1, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 2, 2, 4, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 0);
      iss(0, 2, 2, 4, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  1, 1, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_WB,  FWD_WB,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // lw $0 ; add $5,$0,$0 -> no forward, no stall
      iss(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 5, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // mult ; mflo -> mflo held while the counter runs 4..1
      iss(0, 1, 2, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 8, 1, 0, 0, 0, 1, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 0, 0, 8, 1, 0, 0, 0, 1, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 0, 0, 8, 1, 0, 0, 0, 1, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 0, 0, 8, 1, 0, 0, 0, 1, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 0, 0, 8, 1, 0, 0, 0, 1, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // mult ; lw $9 ; mult $9,$1 -> load-use and md-busy overlap, then md-only stall
      iss(0, 1, 2, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 1, 9, 9, 1, 1, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 9, 1, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 9, 1, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  1, 0, 1, 1);
      iss(0, 9, 1, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 1);
      iss(0, 9, 1, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // addi $7 ; beq $7,$0
      iss(0, 1, 7, 7, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 0);
`ifdef BRANCH_FWD_EN
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  1, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_WB,  FWD_RF,  0, 0, 0, 0);
`else
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 0);
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
`endif
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // lw $7 ; beq $7,$0 -> stalls until the load reaches WB in both builds
      iss(0, 1, 7, 7, 1, 1, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 0);
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  1, 0, 1, 0);
      iss(0, 7, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // reset during a load-use stall
      iss(0, 1, 2, 2, 1, 1, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(1, 2, 2, 4, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 1, 0);
      iss(0, 2, 2, 4, 1, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      // reset while mult/div busy
      iss(0, 1, 2, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 1);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FWD_RF,  FWD_RF,  0, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      check("scoreboard_drained", (sb_q.size() == 0) ? 2'd1 : 2'd0, 2'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
